// File: rtl/flag_register_if.sv
// Bundles the flag-register inputs (instruction side) and flag outputs
// (branch/hazard side) between the pipeline and flag_register.
interface flag_register_if;
  logic        En;
  logic        Stall;
  logic        Flush;
  logic [3:0]  Opcode;
  logic [15:0] Result;
  logic        Ovfl;
  logic [2:0]  F_out;
  logic [2:0]  F_fwd;
  logic        Busy;
  logic        Halted;

  modport master (
    output En, Stall, Flush, Opcode, Result, Ovfl,
    input  F_out, F_fwd, Busy, Halted
  );

  modport slave (
    input  En, Stall, Flush, Opcode, Result, Ovfl,
    output F_out, F_fwd, Busy, Halted
  );
endinterface

// File: rtl/flag_register.sv
// Condition-flag register {N, V, Z}: one-cycle pending stage, then commit.
// Optional macro FLAG_FWD_EN bypasses the pending update onto F_fwd and ties Busy low.
module flag_register #(
  parameter logic [2:0] FLAG_RESET = 3'b000
) (
  input  logic           clk,
  input  logic           rst_n,
  flag_register_if.slave bus
);

  logic [2:0] mask;
  logic       is_hlt;
  logic [2:0] new_val;
  logic       accept;
  logic [2:0] f_out;
  logic [2:0] merged;
  logic       p_valid;
  logic [2:0] p_mask;
  logic [2:0] p_val;
  logic       halted;

  always_comb begin
    mask   = 3'b000;
    is_hlt = 1'b0;
    case (bus.Opcode)
      4'b0000, 4'b0001:                   mask = 3'b111;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: mask = 3'b001;
      4'b1111:                            is_hlt = 1'b1;
      default:                            mask = 3'b000;
    endcase
  end

  assign new_val = {bus.Result[15], bus.Ovfl, (bus.Result == 16'h0000)};
  assign accept  = bus.En & ~bus.Flush & ~bus.Stall & ~halted;
  assign merged  = (f_out & ~p_mask) | (p_val & p_mask);

  // Commit of the older update and capture of the newer one share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_out   <= FLAG_RESET;
      p_valid <= 1'b0;
      p_mask  <= 3'b000;
      p_val   <= 3'b000;
      halted  <= 1'b0;
    end else if (!bus.Stall) begin
      p_valid <= accept & (mask != 3'b000);
      p_mask  <= mask;
      p_val   <= new_val;
      if (p_valid)
        f_out <= merged;
      if (accept && is_hlt)
        halted <= 1'b1;
    end
  end

  assign bus.F_out  = f_out;
  assign bus.Halted = halted;

`ifdef FLAG_FWD_EN
  assign bus.F_fwd = p_valid ? merged : f_out;
  assign bus.Busy  = 1'b0;
`else
  assign bus.F_fwd = f_out;
  assign bus.Busy  = p_valid;
`endif

endmodule

// File: doc/flag_register.md
Name: flag_register

Overview:
Sequential producer of the {N, V, Z} condition flags that the branch/PC-control logic consumes.
- Takes the ALU result of each executed instruction and decodes from the opcode which flags that instruction writes.
- Stages the update for one cycle, then commits it to the architectural flag register.
- Provides a forwarded flag view, a busy indication for the hazard unit, and a sticky halt indication for HLT.

Parameters:
FLAG_RESET, 3'b000, reset value of the committed flags {N, V, Z}.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
En  input  1  instruction presented this cycle is valid.
Stall  input  1  pipeline stall; freezes all state.
Flush  input  1  discard the instruction presented this cycle.
Opcode  input  4  opcode of the presented instruction.
Result  input  16  ALU result of the presented instruction.
Ovfl  input  1  ALU signed-overflow indication for Result.
F_out  output  3  committed flags {N, V, Z}.
F_fwd  output  3  flags as seen by a branch this cycle (see Optional Feature).
Busy  output  1  a flag update is pending, not yet committed.
Halted  output  1  sticky; HLT has been accepted.

Behaviour:
- Opcode decode:
  - 0000 ADD and 0001 SUB write mask 3'b111.
  - 0010 XOR, 0100 SLL, 0101 SRA and 0110 ROR write mask 3'b001 (Z only).
  - All other opcodes write mask 3'b000.
  - 1111 is HLT.
- New flag values: N = Result[15]; V = Ovfl; Z = (Result == 16'h0000).
- Accept = En & ~Flush & ~Stall & ~Halted.
- Pending stage registers: P_valid, P_mask[2:0], P_val[2:0].
  - On a clk edge with ~Stall, P_valid <= Accept & (mask != 0); P_mask and P_val load the decoded mask and new values.
  - Opcodes with mask 0 leave P_valid = 0.
- Commit: on a clk edge with ~Stall and P_valid = 1, F_out <= (F_out & ~P_mask) | (P_val & P_mask).
  - Commit and capture of a new update occur in the same edge.
  - Back-to-back flag writers therefore commit on consecutive cycles.
- Latency: an accepted update appears on F_out 2 edges after the instruction is presented.
- Stall = 1: F_out, P_* and Halted all hold. Stall dominates Flush and En.
- Flush = 1 (with Stall = 0): only the presented instruction is discarded. An already-pending update still commits.
- Halt:
  - Accept with Opcode 1111 sets Halted on the next edge.
  - Once Halted = 1, En is ignored, but an outstanding pending update still drains.
  - Halted clears only on reset.
- Busy = P_valid when FLAG_FWD_EN is undefined; constant 0 when it is defined.
- Reset (rst_n = 0, asynchronous): F_out = FLAG_RESET, P_valid = 0, P_mask = 0, P_val = 0, Halted = 0, Busy = 0, F_fwd = FLAG_RESET.
- Reset asserted mid-operation drops any pending update immediately; no partial commit.

Optional Feature:
Macro FLAG_FWD_EN.
- Defined: F_fwd = P_valid ? ((F_out & ~P_mask) | (P_val & P_mask)) : F_out, i.e. the pending update is bypassed combinationally so a branch directly following a flag writer sees its flags. Busy is tied to 0.
- Undefined: F_fwd = F_out and Busy = P_valid. The hazard unit stalls branches while Busy = 1.

Test Plan:
- Reset with FLAG_RESET=3'b010, then release → F_out=3'b010, Busy=0, Halted=0; no change with En=0 for 5 cycles.
- SUB with Result=16'h0000, Ovfl=0, from F=3'b000 → F_out=3'b001 two edges later. Without FLAG_FWD_EN, Busy=1 for exactly one cycle. With FLAG_FWD_EN, F_fwd=3'b001 one edge after presentation.
- ADD with Result=16'h8000, Ovfl=1 (F→3'b110), immediately followed by XOR with Result=16'h0000 → F_out=3'b110, then 3'b111 on the next edge (XOR leaves N and V untouched).
- ADD with Result=0 presented with Flush=1 → F_out unchanged. An older pending update committing in the same cycle still lands.
- Pending update with Stall held 3 cycles → F_out, Busy, F_fwd frozen; update commits on the first edge after Stall drops.
- HLT accepted, then ADD presented → Halted=1 on the next edge, ADD ignored, F_out unchanged. rst_n pulse low → Halted=0.
